// File: rtl/mc_controller.sv
// Multi-cycle processor control unit: Moore sequencing FSM, ALU op decode,
// NZCV flag register and condition-code gating.
module mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic        MulSel,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic [3:0]  Flags
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_flags;

   logic [1:0]  w_op;
   logic [5:0]  w_funct;
   logic        w_rd_pc;
   logic        w_is_mul;
   logic        w_is_cmp;
   logic        w_dp_valid;
   logic        w_dp_wr;
   logic        w_cv_wr;
   logic        w_flag_wr;
   logic [2:0]  w_alu_ctrl;
   logic        w_cond_ex;
   logic        w_n, w_z, w_c, w_v;
   logic        w_unused;

   assign w_op      = Instr[27:26];
   assign w_funct   = Instr[25:20];
   assign w_rd_pc   = (Instr[15:12] == 4'hF);
   assign {w_n, w_z, w_c, w_v} = r_flags;
   assign w_unused  = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

   assign Flags     = r_flags;
   assign ImmSrc    = w_op;
   assign RegSrc    = {(w_op == 2'b01), (w_op == 2'b10)};

   // Data-processing decode: ALU op, whether Rd is written, whether C/V are touched
   always_comb begin
      w_is_mul   = (w_op == 2'b00) && (w_funct[5:1] == 5'b00000) && (Instr[7:4] == 4'b1001);
      w_is_cmp   = 1'b0;
      w_alu_ctrl = 3'b000;
      w_dp_valid = 1'b1;
      w_dp_wr    = 1'b0;
      w_cv_wr    = 1'b0;
      if (w_is_mul) begin
         w_alu_ctrl = 3'b100;
         w_dp_wr    = 1'b1;
      end else begin
         case (w_funct[4:1])
            4'b0100: begin w_alu_ctrl = 3'b000; w_dp_wr = 1'b1; w_cv_wr = 1'b1; end
            4'b0010: begin w_alu_ctrl = 3'b001; w_dp_wr = 1'b1; w_cv_wr = 1'b1; end
            4'b0000: begin w_alu_ctrl = 3'b010; w_dp_wr = 1'b1; end
            4'b1100: begin w_alu_ctrl = 3'b011; w_dp_wr = 1'b1; end
            4'b1010: begin w_alu_ctrl = 3'b001; w_cv_wr = 1'b1; w_is_cmp = 1'b1; end
            default: w_dp_valid = 1'b0;
         endcase
      end
      w_flag_wr = w_dp_valid && (w_funct[0] || w_is_cmp);
   end

   // Condition field evaluated against the architectural flags
   always_comb begin
      w_cond_ex = 1'b0;
      case (Instr[31:28])
         4'b0000: w_cond_ex = w_z;
         4'b0001: w_cond_ex = !w_z;
         4'b0010: w_cond_ex = w_c;
         4'b0011: w_cond_ex = !w_c;
         4'b0100: w_cond_ex = w_n;
         4'b0101: w_cond_ex = !w_n;
         4'b0110: w_cond_ex = w_v;
         4'b0111: w_cond_ex = !w_v;
         4'b1000: w_cond_ex = w_c && !w_z;
         4'b1001: w_cond_ex = !w_c || w_z;
         4'b1010: w_cond_ex = (w_n == w_v);
         4'b1011: w_cond_ex = (w_n != w_v);
         4'b1100: w_cond_ex = !w_z && (w_n == w_v);
         4'b1101: w_cond_ex = w_z || (w_n != w_v);
         4'b1110: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= FETCH;
         r_flags <= 4'b0000;
      end else begin
         r_state <= w_next;
         if ((r_state == EXECR || r_state == EXECI) && w_flag_wr) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_cv_wr) r_flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Next state and Moore outputs
   always_comb begin
      w_next     = r_state;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MulSel     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 3'b000;
      case (r_state)
         FETCH: begin
            IRWrite = 1'b1; PCWrite = 1'b1;
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            w_next  = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            if (!w_cond_ex || w_op == 2'b11) w_next = FETCH;
            else if (w_op == 2'b01)         w_next = MEMADR;
            else if (w_op == 2'b10)         w_next = BRANCH;
            else if (w_funct[5])            w_next = EXECI;
            else                            w_next = EXECR;
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            w_next  = w_funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            w_next = MEMWB;
         end
         MEMWR: begin
            AdrSrc = 1'b1; MemWrite = 1'b1;
            w_next = FETCH;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            PCWrite   = w_rd_pc;
            RegWrite  = !w_rd_pc;
            w_next    = FETCH;
         end
         EXECR: begin
            ALUControl = w_alu_ctrl; MulSel = w_is_mul;
            w_next     = ALUWB;
         end
         EXECI: begin
            ALUSrcB = 2'b01; ALUControl = w_alu_ctrl;
            w_next  = ALUWB;
         end
         ALUWB: begin
            MulSel   = w_is_mul;
            PCWrite  = w_dp_wr && w_rd_pc;
            RegWrite = w_dp_wr && !w_rd_pc;
            w_next   = FETCH;
         end
         BRANCH: begin
            ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1;
            w_next  = FETCH;
         end
         default: w_next = FETCH;
      endcase
      // Under reset the enables are held off and the muxes park on fetch values
      if (!reset) begin
         PCWrite = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0;
         AdrSrc = 1'b0; MulSel = 1'b0; ALUControl = 3'b000;
         ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction sequence plus
// randomized instructions/resets against a per-instruction path model.
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, MulSel;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;
   logic [3:0]  Flags;

   always #5 clk = ~clk;

   mc_controller dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .AdrSrc(AdrSrc), .RegSrc(RegSrc), .MulSel(MulSel), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .Flags(Flags)
   );

   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                  P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;
   localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_ORR = 3, C_CMP = 4, C_MUL = 5, C_UNS = 6;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          path[$];
   logic [3:0]  mflags = 4'b0000;
   logic [22:0] exp_vec;
   logic [22:0] dut_vec;

   assign dut_vec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, MulSel,
                     ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Flags};

   function automatic int alu_class(input logic [31:0] ins);
      if (ins[27:26] == 2'b00 && ins[25:21] == 5'b0 && ins[7:4] == 4'b1001) return C_MUL;
      case (ins[24:21])
         4'b0100: return C_ADD;
         4'b0010: return C_SUB;
         4'b0000: return C_AND;
         4'b1100: return C_ORR;
         4'b1010: return C_CMP;
         default: return C_UNS;
      endcase
   endfunction

   function automatic logic [2:0] alu_code(input int cls);
      case (cls)
         C_SUB, C_CMP: return 3'b001;
         C_AND:        return 3'b010;
         C_ORR:        return 3'b011;
         C_MUL:        return 3'b100;
         default:      return 3'b000;
      endcase
   endfunction

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'h0: return z;          4'h1: return !z;
         4'h2: return cf;         4'h3: return !cf;
         4'h4: return n;          4'h5: return !n;
         4'h6: return v;          4'h7: return !v;
         4'h8: return cf && !z;   4'h9: return !cf || z;
         4'hA: return n == v;     4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [22:0] mk(input logic pcw, input logic mw, input logic rw,
                                      input logic irw, input logic adr, input logic msel,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] r, input logic [2:0] alu);
      logic [1:0] op;
      op = Instr[27:26];
      return {pcw, mw, rw, irw, adr, (op == 2'b01), (op == 2'b10), msel, a, b, r, op, alu, mflags};
   endfunction

   // Whole step sequence of the instruction, decided at its fetch
   task automatic build_path();
      logic [1:0] op;
      op = Instr[27:26];
      path.delete();
      path.push_back(P_FETCH);
      path.push_back(P_DECODE);
      if (cond_ok(Instr[31:28], mflags) && op != 2'b11) begin
         case (op)
            2'b00: begin
               path.push_back(Instr[25] ? P_EXECI : P_EXECR);
               path.push_back(P_ALUWB);
            end
            2'b01: begin
               path.push_back(P_MEMADR);
               if (Instr[20]) begin path.push_back(P_MEMRD); path.push_back(P_MEMWB); end
               else           path.push_back(P_MEMWR);
            end
            default: path.push_back(P_BRANCH);
         endcase
      end
   endtask

   function automatic logic [22:0] expect_now();
      int   cls;
      logic pc15, wr;
      cls  = alu_class(Instr);
      pc15 = (Instr[15:12] == 4'hF);
      wr   = (cls != C_CMP) && (cls != C_UNS);
      if (!reset || path.size() == 0) return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000);
      case (path[0])
         P_FETCH:  return mk(1, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000);
         P_DECODE: return mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 3'b000);
         P_MEMADR: return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 3'b000);
         P_MEMRD:  return mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000);
         P_MEMWR:  return mk(0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000);
         P_MEMWB:  return mk(pc15, 0, !pc15, 0, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000);
         P_EXECR:  return mk(0, 0, 0, 0, 0, cls == C_MUL, 2'b00, 2'b00, 2'b00, alu_code(cls));
         P_EXECI:  return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, alu_code(cls));
         P_ALUWB:  return mk(wr && pc15, 0, wr && !pc15, 0, 0, cls == C_MUL,
                             2'b00, 2'b00, 2'b00, 3'b000);
         default:  return mk(1, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 3'b000);
      endcase
   endfunction

   task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: retire the model across the edge, drive the next cycle, compare every output
   task automatic step(input logic rst, input logic [31:0] ins, input logic [3:0] af);
      int cls;
      @(posedge clk);
      if (!reset) begin
         mflags = 4'b0000;
         path.delete();
      end else if (path.size() > 0) begin
         if (path[0] == P_EXECR || path[0] == P_EXECI) begin
            cls = alu_class(Instr);
            if (cls != C_UNS && (Instr[20] || cls == C_CMP)) begin
               mflags[3:2] = ALUFlags[3:2];
               if (cls == C_ADD || cls == C_SUB || cls == C_CMP) mflags[1:0] = ALUFlags[1:0];
            end
         end
         void'(path.pop_front());
      end
      #1;
      reset    = rst;
      ALUFlags = af;
      if (rst && path.size() == 0) begin
         Instr = ins;
         build_path();
      end
      exp_vec = expect_now();
      cyc++;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
         errors++;
         $display("FAIL cycle %0d outputs: got %h expected %h instr %h", cyc, dut_vec, exp_vec, Instr);
      end
   endtask

   task automatic run(input logic [31:0] ins, input logic [3:0] af, input int len);
      step(1'b1, ins, af);
      check_lit("fetch_enables", 8'({IRWrite, PCWrite}), 8'b11);
      check_lit("path_len", 8'(path.size()), 8'(len));
      for (int i = 1; i < len; i++) step(1'b1, ins, af);
   endtask

   function automatic logic [3:0] pick_cmd();
      case ($urandom_range(0, 5))
         0: return 4'b0100;
         1: return 4'b0010;
         2: return 4'b0000;
         3: return 4'b1100;
         4: return 4'b1010;
         default: return 4'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[31:28] = 4'hE;
      case ($urandom_range(0, 7))
         0, 1: begin r[27:25] = 3'b000; r[24:21] = pick_cmd(); end
         2:    begin r[27:25] = 3'b001; r[24:21] = pick_cmd(); end
         3:    begin r[27:21] = 7'b0; r[7:4] = 4'b1001; end
         4:    r[27:26] = 2'b01;
         5:    r[27:26] = 2'b10;
         6:    r[27:26] = 2'b11;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      reset    = 1'b0;
      Instr    = 32'h0;
      ALUFlags = 4'h0;

      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 4'hF);
      check_lit("rst_enables", 8'({PCWrite, MemWrite, RegWrite, IRWrite}), 8'h0);
      check_lit("rst_flags", 8'(Flags), 8'h0);

      run(32'hE0910002, 4'b0110, 4);           // ADDS
      check_lit("adds_regwrite", 8'(RegWrite), 8'h1);
      check_lit("adds_flags", 8'(Flags), 8'b0110);

      run(32'hE1510002, 4'b0100, 4);           // CMP
      check_lit("cmp_regwrite", 8'(RegWrite), 8'h0);
      check_lit("cmp_flags", 8'(Flags), 8'b0100);

      run(32'h0A000003, 4'h0, 3);              // BEQ taken
      check_lit("beq_pcwrite", 8'(PCWrite), 8'h1);
      check_lit("beq_srca", 8'(ALUSrcA), 8'b10);

      run(32'h1A000003, 4'h0, 2);              // BNE not taken

      run(32'hE5912004, 4'h0, 5);              // LDR
      check_lit("ldr_resultsrc", 8'(ResultSrc), 8'b01);
      check_lit("ldr_regwrite", 8'(RegWrite), 8'h1);

      run(32'hE5812004, 4'h0, 4);              // STR
      check_lit("str_memwrite", 8'(MemWrite), 8'h1);

      run(32'hE1510002, 4'b0001, 4);           // CMP leaving 0001
      check_lit("cmp2_flags", 8'(Flags), 8'b0001);

      run(32'hE0120391, 4'b1011, 4);           // MULS
      check_lit("muls_mulsel", 8'(MulSel), 8'h1);
      check_lit("muls_flags", 8'(Flags), 8'b1001);

      for (int c = 0; c < 3000; c++)
         step(($urandom_range(0, 49) != 0), rand_instr(), 4'($urandom));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
